// File: rtl/pio_pin_arbiter.sv
// pio_pin_arbiter
//   Registered per-pin arbiter between the PIO state machines and the pad
//   drivers. Each pin selects a winning SM every cycle. The default winner is
//   the lowest-index driver. In sticky mode, the current owner keeps the pin
//   for as long as it continues to drive. The winner's value and enable appear
//   on core_output/core_drive one clock later. Pins where more than one SM
//   drove are reported as a 1-cycle conflict pulse. A saturating counter
//   counts the cycles in which any pin was in conflict.
//
//   Ports
//     clk            system clock
//     rst_n          asynchronous active-low reset
//     sm_output      SM k value for pin i at bit [k*NUM_PINS+i]
//     sm_drive       SM k drive-enable for pin i, same packing
//     sticky_mode    per pin: 1 = sticky ownership, 0 = fixed priority
//     count_clear    synchronous clear of conflict_count (wins over increment)
//     core_output    registered pin value
//     core_drive     registered pin output enable
//     owner_valid    pin currently owned
//     owner_id       owning SM of pin i at [i*OWNER_W +: OWNER_W]
//     conflict       pin i had two or more drivers in the previous cycle
//     conflict_count saturating count of cycles with any conflict
module pio_pin_arbiter #(
  parameter int NUM_SM   = 4,
  parameter int NUM_PINS = 32,
  parameter int CNT_W    = 16,
  localparam int OWNER_W = (NUM_SM > 1) ? $clog2(NUM_SM) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_SM*NUM_PINS-1:0]  sm_output,
  input  logic [NUM_SM*NUM_PINS-1:0]  sm_drive,
  input  logic [NUM_PINS-1:0]         sticky_mode,
  input  logic                        count_clear,
  output logic [NUM_PINS-1:0]         core_output,
  output logic [NUM_PINS-1:0]         core_drive,
  output logic [NUM_PINS-1:0]         owner_valid,
  output logic [NUM_PINS*OWNER_W-1:0] owner_id,
  output logic [NUM_PINS-1:0]         conflict,
  output logic [CNT_W-1:0]            conflict_count
);

  logic [NUM_PINS-1:0]         core_output_reg;
  logic [NUM_PINS-1:0]         core_drive_reg;
  logic [NUM_PINS-1:0]         owner_valid_reg;
  logic [NUM_PINS*OWNER_W-1:0] owner_id_reg;
  logic [NUM_PINS-1:0]         conflict_reg;
  logic [CNT_W-1:0]            count_reg;

  logic [NUM_PINS-1:0]         win_valid_next;
  logic [NUM_PINS-1:0]         win_value_next;
  logic [NUM_PINS*OWNER_W-1:0] win_id_next;
  logic [NUM_PINS-1:0]         conflict_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PINS; gi++) begin : g_pin
      logic               found;
      logic               multi;
      logic               value;
      logic [OWNER_W-1:0] win;
      logic [OWNER_W-1:0] owner_cur;

      assign owner_cur = owner_id_reg[gi*OWNER_W +: OWNER_W];

      always_comb begin
        found = 1'b0;
        multi = 1'b0;
        value = 1'b0;
        win   = '0;
        // The scan runs from high to low index, so the last hit is the
        // lowest-index driver. Any earlier hit means there are two or more
        // drivers.
        for (int k = NUM_SM - 1; k >= 0; k--) begin
          if (sm_drive[k*NUM_PINS+gi]) begin
            if (found) multi = 1'b1;
            found = 1'b1;
            win   = OWNER_W'(k);
            value = sm_output[k*NUM_PINS+gi];
          end
        end
        // A sticky owner that is still driving overrides the priority
        // pick. This uses the owner register from the previous cycle, so a
        // change to sticky_mode applies immediately.
        if (sticky_mode[gi] && owner_valid_reg[gi]) begin
          for (int k = 0; k < NUM_SM; k++) begin
            if (sm_drive[k*NUM_PINS+gi] && (owner_cur == OWNER_W'(k))) begin
              win   = OWNER_W'(k);
              value = sm_output[k*NUM_PINS+gi];
            end
          end
        end
      end

      assign win_valid_next[gi]                    = found;
      assign win_value_next[gi]                    = value;
      assign win_id_next[gi*OWNER_W +: OWNER_W]    = win;
      assign conflict_next[gi]                     = multi;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_output_reg <= '0;
      core_drive_reg  <= '0;
      owner_valid_reg <= '0;
      owner_id_reg    <= '0;
      conflict_reg    <= '0;
      count_reg       <= '0;
    end else begin
      // With no winner, value and id are already 0 in the selection logic.
      core_output_reg <= win_value_next;
      core_drive_reg  <= win_valid_next;
      owner_valid_reg <= win_valid_next;
      owner_id_reg    <= win_id_next;
      conflict_reg    <= conflict_next;
      if (count_clear) begin
        count_reg <= '0;
      end else if ((|conflict_next) && (count_reg != {CNT_W{1'b1}})) begin
        count_reg <= count_reg + CNT_W'(1);
      end
    end
  end

  assign core_output    = core_output_reg;
  assign core_drive     = core_drive_reg;
  assign owner_valid    = owner_valid_reg;
  assign owner_id       = owner_id_reg;
  assign conflict       = conflict_reg;
  assign conflict_count = count_reg;

endmodule

// File: tb/tb_pio_pin_arbiter.sv
// Testbench for pio_pin_arbiter: 4 SMs, 8 pins, 2-bit conflict counter.
// The stimulus drives one vector per cycle at the falling edge and queues the
// hand-computed expected outputs for that vector. The monitor checks the DUT
// 1 ns after every rising edge against the head of the queue.
module tb_pio_pin_arbiter;

  localparam int NSM = 4;
  localparam int NP  = 8;
  localparam int CW  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   sm_output = '0;
  logic [31:0]   sm_drive = '0;
  logic [7:0]    sticky_mode = '0;
  logic          count_clear = 1'b0;
  logic [7:0]    core_output;
  logic [7:0]    core_drive;
  logic [7:0]    owner_valid;
  logic [15:0]   owner_id;
  logic [7:0]    conflict;
  logic [1:0]    conflict_count;

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  typedef struct {
    string       name;
    logic [7:0]  o;
    logic [7:0]  d;
    logic [7:0]  ov;
    logic [15:0] id;
    logic [7:0]  cf;
    logic [1:0]  cnt;
  } exp_t;

  exp_t exp_q[$];

  pio_pin_arbiter #(.NUM_SM(NSM), .NUM_PINS(NP), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .sm_output(sm_output), .sm_drive(sm_drive),
    .sticky_mode(sticky_mode), .count_clear(count_clear),
    .core_output(core_output), .core_drive(core_drive),
    .owner_valid(owner_valid), .owner_id(owner_id),
    .conflict(conflict), .conflict_count(conflict_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] b(input int k, input int i);
    return 32'(1) << (k*NP + i);
  endfunction

  task automatic cmp(input string nm, input string fld,
                     input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, expv);
    end
  endtask

  // Drives one vector and queues the outputs expected after the next edge.
  task automatic vec(input string nm, input logic rst, input logic [31:0] drv,
                     input logic [31:0] outv, input logic [7:0] st, input logic clr,
                     input logic [7:0] eo, input logic [7:0] ed, input logic [7:0] eov,
                     input logic [15:0] eid, input logic [7:0] ecf, input logic [1:0] ecnt);
    exp_t e;
    @(negedge clk);
    rst_n       = rst;
    sm_drive    = drv;
    sm_output   = outv;
    sticky_mode = st;
    count_clear = clr;
    e.name = nm; e.o = eo; e.d = ed; e.ov = eov; e.id = eid; e.cf = ecf; e.cnt = ecnt;
    exp_q.push_back(e);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        txn++;
        cmp(e.name, "core_output", {8'h0, core_output}, {8'h0, e.o});
        cmp(e.name, "core_drive", {8'h0, core_drive}, {8'h0, e.d});
        cmp(e.name, "owner_valid", {8'h0, owner_valid}, {8'h0, e.ov});
        cmp(e.name, "owner_id", owner_id, e.id);
        cmp(e.name, "conflict", {8'h0, conflict}, {8'h0, e.cf});
        cmp(e.name, "conflict_count", {14'h0, conflict_count}, {14'h0, e.cnt});
        $display("txn %0d %s: out=%h drv=%h ov=%h id=%h cf=%h cnt=%0d",
                 txn, e.name, core_output, core_drive, owner_valid, owner_id,
                 conflict, conflict_count);
      end
    end
  end

  // Stimulus
  initial begin
    // Reset held low while the inputs are random.
    for (int n = 0; n < 3; n++)
      vec("reset_rand", 1'b0, $urandom, $urandom, 8'($urandom), 1'($urandom),
          8'h00, 8'h00, 8'h00, 16'h0000, 8'h00, 2'd0);
    vec("reset_release", 1'b1, 32'h0, 32'h0, 8'h00, 1'b0,
        8'h00, 8'h00, 8'h00, 16'h0000, 8'h00, 2'd0);
    vec("idle", 1'b1, 32'h0, 32'h0, 8'h00, 1'b0,
        8'h00, 8'h00, 8'h00, 16'h0000, 8'h00, 2'd0);

    // Fixed priority: SM1 (value 1) beats SM2 (value 0) on pin 5.
    vec("fixed_p5", 1'b1, b(1,5) | b(2,5), b(1,5), 8'h00, 1'b0,
        8'h20, 8'h20, 8'h20, 16'h0400, 8'h20, 2'd1);
    vec("idle2", 1'b1, 32'h0, 32'h0, 8'h00, 1'b0,
        8'h00, 8'h00, 8'h00, 16'h0000, 8'h00, 2'd1);

    // Sticky hold on pin 3: SM2 owns the pin, then SM0 joins.
    vec("sticky_own1", 1'b1, b(2,3), 32'h0, 8'h08, 1'b0,
        8'h00, 8'h08, 8'h08, 16'h0080, 8'h00, 2'd1);
    vec("sticky_own2", 1'b1, b(2,3), 32'h0, 8'h08, 1'b0,
        8'h00, 8'h08, 8'h08, 16'h0080, 8'h00, 2'd1);
    vec("sticky_hold1", 1'b1, b(2,3) | b(0,3), b(0,3), 8'h08, 1'b0,
        8'h00, 8'h08, 8'h08, 16'h0080, 8'h08, 2'd2);
    vec("sticky_hold2", 1'b1, b(2,3) | b(0,3), b(0,3), 8'h08, 1'b0,
        8'h00, 8'h08, 8'h08, 16'h0080, 8'h08, 2'd3);
    vec("sticky_sat", 1'b1, b(2,3) | b(0,3), b(0,3), 8'h08, 1'b0,
        8'h00, 8'h08, 8'h08, 16'h0080, 8'h08, 2'd3);
    // Handoff: SM2 drops and SM0 takes over with no gap in drive.
    vec("sticky_handoff", 1'b1, b(0,3), b(0,3), 8'h08, 1'b0,
        8'h08, 8'h08, 8'h08, 16'h0000, 8'h00, 2'd3);

    // Fixed mode: an existing owner loses to a lower index.
    vec("fixed_own2", 1'b1, b(2,3), b(2,3), 8'h00, 1'b0,
        8'h08, 8'h08, 8'h08, 16'h0080, 8'h00, 2'd3);
    vec("fixed_preempt", 1'b1, b(2,3) | b(0,3), b(2,3), 8'h00, 1'b0,
        8'h00, 8'h08, 8'h08, 16'h0000, 8'h08, 2'd3);
    // Clear takes priority over a conflict in the same cycle.
    vec("clear_conflict", 1'b1, b(2,3) | b(0,3), b(2,3), 8'h00, 1'b1,
        8'h00, 8'h08, 8'h08, 16'h0000, 8'h08, 2'd0);
    vec("count_after_clr", 1'b1, b(2,3) | b(0,3), b(2,3), 8'h00, 1'b0,
        8'h00, 8'h08, 8'h08, 16'h0000, 8'h08, 2'd1);

    // An owner that drops drive for one cycle loses ownership.
    vec("drop_own", 1'b1, b(2,3), b(2,3), 8'h08, 1'b0,
        8'h08, 8'h08, 8'h08, 16'h0080, 8'h00, 2'd1);
    vec("drop_gap", 1'b1, 32'h0, 32'h0, 8'h08, 1'b0,
        8'h00, 8'h00, 8'h00, 16'h0000, 8'h00, 2'd1);
    vec("drop_rearb", 1'b1, b(2,3) | b(1,3), b(2,3), 8'h08, 1'b0,
        8'h00, 8'h08, 8'h08, 16'h0040, 8'h08, 2'd2);

    // Async reset while SM1 owns pin 3 in sticky mode.
    vec("pre_reset_hold", 1'b1, b(1,3) | b(0,3), b(0,3), 8'h08, 1'b0,
        8'h00, 8'h08, 8'h08, 16'h0040, 8'h08, 2'd3);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    cmp("async_reset", "core_output", {8'h0, core_output}, 16'h0);
    cmp("async_reset", "core_drive", {8'h0, core_drive}, 16'h0);
    cmp("async_reset", "owner_valid", {8'h0, owner_valid}, 16'h0);
    cmp("async_reset", "owner_id", owner_id, 16'h0);
    cmp("async_reset", "conflict", {8'h0, conflict}, 16'h0);
    cmp("async_reset", "conflict_count", {14'h0, conflict_count}, 16'h0);
    $display("txn async_reset: out=%h drv=%h ov=%h id=%h cf=%h cnt=%0d",
             core_output, core_drive, owner_valid, owner_id, conflict, conflict_count);
    vec("reset_held", 1'b0, b(1,3) | b(0,3), b(0,3), 8'h08, 1'b0,
        8'h00, 8'h00, 8'h00, 16'h0000, 8'h00, 2'd0);
    // Ownership was lost, so SM0 (value 1) now wins.
    vec("post_reset_rearb", 1'b1, b(1,3) | b(0,3), b(0,3), 8'h08, 1'b0,
        8'h08, 8'h08, 8'h08, 16'h0000, 8'h08, 2'd1);

    // Let the monitor drain the queue, within a bounded number of cycles.
    for (int n = 0; n < 10 && exp_q.size() > 0; n++) @(posedge clk);
    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
